cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_W, default 128, width in bits of one cache line (pmem data bus).
REQ-002 Clock and reset: the block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_pmem_read  in  1  I-cache line-fill request; held high until i_pmem_resp.
REQ-006 i_pmem_address  in  16  I-cache line address (lc3b_word).
REQ-007 i_pmem_rdata / i_pmem_resp  out  LINE_W / 1  fill data / one-cycle completion to I-cache.
REQ-008 d_pmem_read, d_pmem_write  in  1 each  D-cache fill / writeback request; mutually exclusive, held until d_pmem_resp.
REQ-009 d_pmem_address / d_pmem_wdata  in  16 / LINE_W  D-cache address / writeback line.
REQ-010 d_pmem_rdata / d_pmem_resp  out  LINE_W / 1  fill data / one-cycle completion to D-cache.
REQ-011 pmem_read, pmem_write, pmem_address, pmem_wdata  out  1, 1, 16, LINE_W  physical-memory request.
REQ-012 pmem_rdata / pmem_resp  in  LINE_W / 1  memory data / one-cycle completion.

Function
REQ-013 FSM states SHALL be IDLE, GNT_I, GNT_D, DONE.
REQ-014 IDLE: pmem_read=pmem_write=0. On a clock edge with at least one request, go to GNT_I or GNT_D per REQ-019/020 and latch the winner's address, wdata and op into internal registers.
REQ-015 GNT_x: pmem_read/pmem_write/pmem_address/pmem_wdata SHALL come only from the latched registers, stable for the whole grant; the first pmem strobe is asserted the cycle after the request is sampled.
REQ-016 GNT_x: pmem_rdata SHALL be forwarded to the granted requester only; the granted requester's resp = pmem_resp, combinational, same cycle. Other requester: resp=0, rdata=0.
REQ-017 On pmem_resp in GNT_x: go to DONE; pmem strobes low from the next cycle.
REQ-018 DONE SHALL last exactly one cycle with no strobes, then go to IDLE. This prevents re-granting a request that is deasserting.
REQ-019 Only one requester active in IDLE: that requester is granted.
REQ-020 Both active in IDLE: D-cache wins (default; see REQ-026).
REQ-021 Requests deasserted during GNT_x before pmem_resp SHALL be ignored; the latched transaction runs to completion.
REQ-022 pmem_resp outside GNT_x SHALL be ignored; no requester resp asserts.
REQ-023 Latency, uncontended: request at edge N -> pmem strobe in cycle N+1 -> requester resp in the same cycle as pmem_resp -> the next grant can start no earlier than 2 cycles after resp.

Reset
REQ-024 While reset_n=0, asynchronously: state=IDLE; latched registers=0; all pmem strobes, resps and rdata outputs=0; round-robin pointer=I-cache-favoured.
REQ-025 Reset asserted mid-grant SHALL abort the transaction; neither requester receives resp. After release, a still-held request is re-arbitrated from IDLE.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last-grant register updates on each entry to DONE. On a tie, the requester not granted last wins.
- Undefined: fixed D-cache priority and no last-grant register. I-cache can starve under continuous D-cache traffic; this is accepted.

Structure
REQ-027 lc3b_types SHALL hold lc3b_word, the LINE_W-wide lc3b_line, and the arb_state_t enum (IDLE, GNT_I, GNT_D, DONE).
REQ-028 Sub-module arb_pick SHALL contain the combinational winner selection (i_req, d_req, last_grant -> grant_i, grant_d). All state stays in cache_arbiter.

Verification
REQ-029 Single I fill: i_read, addr 0x1240 at edge 0; pmem_resp in cycle 4 with rdata 0xA5..A5 -> pmem_read=1 and pmem_address=0x1240 in cycles 1-4; i_resp=1 and i_rdata=0xA5..A5 in cycle 4 only; d_resp stays 0.
REQ-030 Simultaneous: i_read @0x0040 and d_write @0x8000 in the same cycle -> D granted first, pmem_write=1 with d_wdata. After DONE, I granted with pmem_read @0x0040. With ARB_ROUND_ROBIN_EN and last grant D, a repeated tie grants I first.
REQ-031 Address change mid-grant: d_pmem_address changes 0x8000->0x9000 during GNT_D -> pmem_address holds 0x8000 until resp.
REQ-032 Held request after resp: I-cache keeps i_read high one cycle after i_resp -> DONE absorbs it; no second grant unless i_read is still high in IDLE.
REQ-033 Reset in GNT_D, cycle 2 -> all outputs 0 immediately, with no clock edge needed; no resp; re-grant from IDLE after release.
REQ-034 Spurious pmem_resp in IDLE -> no requester resp and no state change.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and arbiter state encoding
package lc3b_types;

    localparam int LC3B_LINE_W = 128;

    typedef logic [15:0]             lc3b_word;
    typedef logic [LC3B_LINE_W-1:0]  lc3b_line;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection between I-cache and D-cache requests
module arb_pick #(
    parameter bit RR_EN = 1'b0
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,   // 1: D-cache was granted last, 0: I-cache was
    output logic grant_i,
    output logic grant_d
);

    logic tie_to_d;

    // On a tie the D-cache wins unless rotation is enabled, in which case the
    // requester that was not served last takes the turn.
    always_comb begin
        tie_to_d = RR_EN ? ~last_grant : 1'b1;
        grant_d  = d_req & (~i_req | tie_to_d);
        grant_i  = i_req & ~grant_d;
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I/D cache to physical memory arbiter; ARB_ROUND_ROBIN_EN enables tie rotation
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              i_pmem_read,
    input  logic [15:0]       i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [15:0]       d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    lc3b_word          addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              grant_i, grant_d;
    logic              last_grant;
    logic              in_grant;

    assign in_grant = (state_q == GNT_I) || (state_q == GNT_D);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    logic last_grant_q;

    // Remember who was served, updated as the grant completes (entry to DONE).
    // Reset value 1 means "D was last", so the first tie favours the I-cache.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (in_grant && pmem_resp) begin
            last_grant_q <= (state_q == GNT_D);
        end
    end

    assign last_grant = last_grant_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_grant = 1'b0;
`endif

    arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_req      (i_pmem_read),
        .d_req      (d_pmem_read | d_pmem_write),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Next-state: arbitrate only in IDLE, finish a grant on pmem_resp, and
    // spend one DONE cycle so a deasserting request is not granted again.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = GNT_D;
                end else if (grant_i) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any grant in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's transaction so the memory side stays stable even
    // if the requester changes its inputs during the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (grant_d) begin
                addr_q  <= d_pmem_address;
                wdata_q <= d_pmem_wdata;
                rd_q    <= d_pmem_read;
                wr_q    <= d_pmem_write;
            end else if (grant_i) begin
                addr_q  <= i_pmem_address;
                wdata_q <= '0;
                rd_q    <= 1'b1;
                wr_q    <= 1'b0;
            end
        end
    end

    // Memory-side request comes only from the latched transaction.
    always_comb begin
        pmem_read    = in_grant & rd_q;
        pmem_write   = in_grant & wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
    end

    // Response and data steered to the granted requester only.
    always_comb begin
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        if (state_q == GNT_I) begin
            i_pmem_resp  = pmem_resp;
            i_pmem_rdata = pmem_rdata;
        end else if (state_q == GNT_D) begin
            d_pmem_resp  = pmem_resp;
            d_pmem_rdata = pmem_rdata;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;

    localparam int LW = 128;

    typedef struct {
        bit          is_d;
        logic [15:0] addr;
        bit          wr;
        logic [LW-1:0] wdata;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          i_pmem_read;
    logic [15:0]   i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [15:0]   d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int   n_chk;
    int   n_fail;
    int   n_resp_exp;
    int   n_resp_seen;
    int   mem_cnt;
    bit   spurious;
    exp_t exp_q[$];
    exp_t cur;
    bit   prev_strobe;
    int   since_resp;

    cache_arbiter #(
        .LINE_W (LW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_of(input logic [15:0] a);
        if (a == 16'h1240) return {16{8'hA5}};
        return {4{a, ~a}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [15:0] a, input bit wr,
                            input logic [LW-1:0] wd, input bit resp);
        exp_t e;
        e.is_d  = is_d;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = wd;
        exp_q.push_back(e);
        if (resp) n_resp_exp++;
    endtask

    // Physical memory model: answers after 4 strobe cycles, optional spurious resp.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        mem_cnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_read || pmem_write) begin
                mem_cnt++;
                if (mem_cnt == 4) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(pmem_address);
                end else begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = '0;
                end
            end else begin
                mem_cnt    = 0;
                pmem_resp  = spurious;
                pmem_rdata = spurious ? {8{16'hDEAD}} : '0;
                spurious   = 1'b0;
            end
        end
    end

    // Monitor: pops expected grants and checks steering of responses.
    initial begin
        prev_strobe = 1'b0;
        since_resp  = 100;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_strobe = 1'b0;
            end else begin
                automatic bit strobe = pmem_read | pmem_write;
                automatic bit gi;
                automatic bit gd;
                if (strobe && !prev_strobe) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_grant addr=%h expected no grant", pmem_address);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("grant_addr", pmem_address, cur.addr);
                        chk("grant_op", {pmem_read, pmem_write}, cur.wr ? 2'b01 : 2'b10);
                        if (cur.wr) chk("grant_wdata", pmem_wdata, cur.wdata);
                        chk("grant_gap_ok", since_resp >= 2, 1);
                    end
                end else if (strobe) begin
                    chk("hold_addr", pmem_address, cur.addr);
                    chk("hold_op", {pmem_read, pmem_write}, cur.wr ? 2'b01 : 2'b10);
                end
                gi = strobe && !cur.is_d;
                gd = strobe && cur.is_d;
                if (gi) begin
                    chk("i_resp", i_pmem_resp, pmem_resp);
                    if (pmem_resp) chk("i_rdata", i_pmem_rdata, line_of(cur.addr));
                end else begin
                    chk("i_idle", {i_pmem_resp, i_pmem_rdata}, '0);
                end
                if (gd) begin
                    chk("d_resp", d_pmem_resp, pmem_resp);
                    if (pmem_resp) chk("d_rdata", d_pmem_rdata, line_of(cur.addr));
                end else begin
                    chk("d_idle", {d_pmem_resp, d_pmem_rdata}, '0);
                end
                if (i_pmem_resp || d_pmem_resp) begin
                    n_resp_seen++;
                    since_resp = 0;
                end else begin
                    since_resp++;
                end
                prev_strobe = strobe;
            end
        end
    end

    task automatic run_i(input logic [15:0] a, input int hold);
        bit got = 1'b0;
        i_pmem_address = a;
        i_pmem_read    = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (i_pmem_resp) got = 1'b1;
        end
        if (!got) chk("i_resp_timeout", 0, 1);
        repeat (1 + hold) @(posedge clk);
        #1 i_pmem_read = 1'b0;
    endtask

    task automatic run_d(input logic [15:0] a, input bit wr, input logic [LW-1:0] wd);
        bit got = 1'b0;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        d_pmem_read    = ~wr;
        d_pmem_write   = wr;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (d_pmem_resp) got = 1'b1;
        end
        if (!got) chk("d_resp_timeout", 0, 1);
        @(posedge clk);
        #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0; n_resp_exp = 0; n_resp_seen = 0;
        spurious = 1'b0;
        reset_n = 1'b0;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("rst_addr", pmem_address, 16'h0000);
        chk("rst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
        chk("rst_rdata", i_pmem_rdata | d_pmem_rdata, '0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single I fill at 0x1240: strobe one cycle after sampling, four strobe cycles.
        #1;
        push_exp(1'b0, 16'h1240, 1'b0, '0, 1'b1);
        fork
            run_i(16'h1240, 0);
            begin
                automatic int k = 0;
                @(posedge clk);
                @(negedge clk);
                chk("lat_strobe", pmem_read, 1'b1);
                while (pmem_read && k < 20) begin
                    k++;
                    @(negedge clk);
                end
                chk("strobe_cycles", k, 4);
            end
        join
        repeat (3) @(posedge clk);

        // Tie: I read 0x0040 vs D write 0x8000; last grant was I, so D first in both builds.
        #1;
        push_exp(1'b1, 16'h8000, 1'b1, {8{16'hBEEF}}, 1'b1);
        push_exp(1'b0, 16'h0040, 1'b0, '0, 1'b1);
        fork
            run_i(16'h0040, 0);
            run_d(16'h8000, 1'b1, {8{16'hBEEF}});
        join
        repeat (3) @(posedge clk);

        // Solo D read, then a repeated tie: fixed priority keeps D first, rotation gives I.
        #1;
        push_exp(1'b1, 16'h2222, 1'b0, '0, 1'b1);
        run_d(16'h2222, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 16'h0440, 1'b0, '0, 1'b1);
        push_exp(1'b1, 16'h3330, 1'b0, '0, 1'b1);
`else
        push_exp(1'b1, 16'h3330, 1'b0, '0, 1'b1);
        push_exp(1'b0, 16'h0440, 1'b0, '0, 1'b1);
`endif
        fork
            run_i(16'h0440, 0);
            run_d(16'h3330, 1'b0, '0);
        join
        repeat (3) @(posedge clk);

        // Address change mid-grant must not disturb pmem_address.
        #1;
        push_exp(1'b1, 16'h8000, 1'b0, '0, 1'b1);
        fork
            run_d(16'h8000, 1'b0, '0);
            begin
                repeat (2) @(posedge clk);
                #1 d_pmem_address = 16'h9000;
            end
        join
        repeat (3) @(posedge clk);

        // I holds its read one cycle past resp: DONE absorbs it, no second grant.
        #1;
        push_exp(1'b0, 16'h5550, 1'b0, '0, 1'b1);
        run_i(16'h5550, 1);
        repeat (4) @(posedge clk);

        // Spurious pmem_resp while idle, then a normal fill still works.
        @(negedge clk);
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push_exp(1'b0, 16'h6660, 1'b0, '0, 1'b1);
        run_i(16'h6660, 0);
        repeat (3) @(posedge clk);

        // Reset in cycle 2 of a D grant aborts it; held request is re-granted.
        #1;
        push_exp(1'b1, 16'hA000, 1'b1, {8{16'h1234}}, 1'b0);
        push_exp(1'b1, 16'hA000, 1'b1, {8{16'h1234}}, 1'b1);
        fork
            run_d(16'hA000, 1'b1, {8{16'h1234}});
            begin
                @(posedge clk);
                @(posedge clk);
                #3 reset_n = 1'b0;
                #1;
                chk("arst_strobes", {pmem_read, pmem_write}, 2'b00);
                chk("arst_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
                chk("arst_wdata", pmem_wdata, '0);
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        repeat (4) @(posedge clk);

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("resp_count", n_resp_seen, n_resp_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
